seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It shares one `seven_seg` hex decoder across `NUM_DIGITS` digits and drives one digit at a time at a programmable refresh rate. A blanking gap between digits suppresses ghosting. Display updates are double-buffered so new values take effect only at frame boundaries, and optional leading-zero suppression is provided. It sits between the numeric datapath (counters, registers) and the board's segment/anode pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of digits scanned; must be ≥ 1.
- `REFRESH_DIV`, 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, 1000: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ `BLANK_CYCLES` < `REFRESH_DIV`.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: scan enable. When low, the display is dark.
- `load` input 1: one-cycle strobe that captures `value`, `dp_in` into the pending buffer.
- `value` input 4*`NUM_DIGITS`: hex nibbles. Nibble i (`value[4i+3:4i]`) is digit i, and digit 0 is least significant.
- `dp_in` input `NUM_DIGITS`: decimal point request per digit, active-high.
- `lz_blank` input 1: leading-zero suppression enable, sampled live.
- `segs` output 7: segment drive, active-low; `segs[0]`=A … `segs[6]`=G. Registered.
- `dp` output 1: decimal point drive, active-low. Registered.
- `an` output `NUM_DIGITS`: anode enables, active-low; `an[i]`=0 selects digit i. Registered.
- `frame_start` output 1: one-cycle pulse when the digit-0 slot begins.
- `pending` output 1: high while a loaded value awaits the next frame boundary.

## Operation
- Decoding: instantiates `seven_seg` on the active nibble of the current digit index, which gives hex 0–F with active-low encoding.
- FSM states are IDLE, BLANK and SHOW.
  - IDLE: `an` all 1, `segs`=7'h7F, `dp`=1. The slot counter `cnt` and digit index `idx` are held at 0. If `en`=1, the next state is BLANK, or SHOW when `BLANK_CYCLES`=0.
  - BLANK: occupies `cnt` 0…`BLANK_CYCLES`-1. Outputs are dark.
  - SHOW: occupies `cnt` `BLANK_CYCLES`…`REFRESH_DIV`-1.
    - `an[idx]`=0 and `segs`=decode(nibble idx).
    - `dp`=~`dp_a[idx]`.
  - End of slot (`cnt`=`REFRESH_DIV`-1):
    - `cnt`→0.
    - `idx`→`idx`+1, wrapping from `NUM_DIGITS`-1 to 0.
    - Next state is BLANK (or SHOW when `BLANK_CYCLES`=0).
  - `en`=0 in any state forces the next state to IDLE, with `cnt` and `idx` reset to 0. Re-enabling always starts at digit 0.
- Double buffering:
  - `load`=1 copies `value`/`dp_in` into the pending registers and sets `pending`=1. A later `load` before the boundary overwrites the pending data.
  - The frame boundary is the end of slot `idx`=`NUM_DIGITS`-1, or the IDLE→scan transition.
  - At the boundary, the active registers take the `load` data if `load`=1 in that cycle, otherwise the pending data if `pending`=1. In either case `pending` clears.
  - While `en`=0, a `load` transfers to the active registers on the next cycle and `pending` stays 0.
- Leading-zero blank:
  - Applies when `lz_blank`=1.
  - Digit i > 0 is suppressed when all active nibbles i…`NUM_DIGITS`-1 are zero.
  - A suppressed digit is dark for its whole slot: `an[i]`=1, `segs`=7'h7F, `dp`=1, including the decimal point.
  - Digit 0 is never suppressed.
- Reset: `an` all 1, `segs`=7'h7F, `dp`=1, `frame_start`=0, `pending`=0; active and pending data are 0; state IDLE, `cnt`=0, `idx`=0.

## Timing
- Outputs are registered one cycle after the state/`cnt`/`idx` they reflect.
- After `rst` falls with `en`=1:
  - The first edge enters BLANK with `idx`=0.
  - `frame_start` is high in the cycle after that edge.
  - `an[0]` goes low `BLANK_CYCLES`+1 cycles after entry.
- Each digit is lit for exactly `REFRESH_DIV`-`BLANK_CYCLES` cycles per frame. The frame period is `NUM_DIGITS`*`REFRESH_DIV` cycles.
- `pending` rises the cycle after `load`. The new value is visible starting with digit 0 of the next frame and never mid-frame.
- Asynchronous `rst` mid-slot blanks all outputs immediately and discards the pending data.
- Only one `an` bit is ever low at a time. All `an` bits are high during BLANK.

## Test plan
Each case uses `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- Reset release with `en`=1, then `load` 16'h12AF, `dp_in`=0. Next frame scans, in order:
  - `an`=4'b1110 with `segs`=7'h0E;
  - `an`=4'b1101 with 7'h08;
  - `an`=4'b1011 with 7'h24;
  - `an`=4'b0111 with 7'h79.
  - Each digit is lit for 6 cycles with 2 dark cycles between digits, and `frame_start` pulses every 32 cycles.
- Mid-frame `load` 16'h0000 while showing 16'h12AF:
  - The current frame finishes with 12AF and `pending`=1 until the boundary.
  - The next frame shows 7'h40 on all digits.
- `lz_blank`=1 and `load` 16'h0005: `an[3:1]` stay 1 and digit 0 shows 7'h12. Load 16'h0000: only digit 0 lit, with 7'h40.
- `dp_in`=4'b0100: `dp`=0 only during the digit-2 SHOW window, and 1 otherwise including BLANK.
- Drop `en` mid-slot at digit 2: on the next cycle and after, `an`=4'hF and `segs`=7'h7F. Re-assert `en`: the scan restarts at digit 0 with a `frame_start` pulse.
- Assert `rst` mid-SHOW with `pending`=1: outputs go dark asynchronously, and `pending`=0 with active data 0 after release.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode seven-segment scan controller with
// blanking gaps, frame-boundary double buffering and leading-zero suppression.
module seven_seg (
  input  logic [3:0] hex,
  output logic [6:0] segs
);
  always_comb begin
    case (hex)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      default: segs = 7'h0E;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    pending
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam state_t FIRST = (BLANK_CYCLES == 0) ? SHOW : BLANK;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              segs_q, segs_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    end_slot, bnd, xfer, lit;
  seven_seg u_dec (.hex(nib), .segs(dec));
  assign nib      = 4'(act_val_q >> {idx_q, 2'b00});
  assign end_slot = (cnt_q == CNT_LAST);
  // A frame boundary is either the first slot after IDLE or the end of the last digit.
  assign bnd      = en & ((state_q == IDLE) | (end_slot & (idx_q == IDX_LAST)));
  assign xfer     = ~en | bnd;
  assign lit      = en & (state_q == SHOW) & ~sup[idx_q];
  // Suppress digit i>0 when it and every more significant nibble are zero.
  always_comb begin
    logic nz;
    nz  = 1'b0;
    sup = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz     = nz | (|act_val_q[4*i +: 4]);
      sup[i] = lz_blank & ~nz & (i != 0);
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = FIRST;
    end else if (end_slot) begin
      state_d = FIRST;
      cnt_d   = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_d == CNT_SHOW) ? SHOW : state_q;
    end
  end
  always_comb begin
    act_val_d     = (xfer & load) ? value : (xfer & pending_q) ? pend_val_q : act_val_q;
    act_dp_d      = (xfer & load) ? dp_in : (xfer & pending_q) ? pend_dp_q : act_dp_q;
    pend_val_d    = load ? value : pend_val_q;
    pend_dp_d     = load ? dp_in : pend_dp_q;
    pending_d     = ~xfer & (load | pending_q);
    an_d          = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    segs_d        = lit ? dec : 7'h7F;
    dp_d          = ~(lit & act_dp_q[idx_q]);
    frame_start_d = bnd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pending_q     <= 1'b0;
      segs_q        <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      pend_val_q    <= pend_val_d;
      pend_dp_q     <= pend_dp_d;
      pending_q     <= pending_d;
      segs_q        <= segs_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign segs        = segs_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scenario tasks plus a randomized run against a frame-position model.
module tb_seg_scan_ctrl;
  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int FR = N * R;
  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] EXP_12AF [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, lz_blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0;
  logic [6:0] segs;
  logic dp, frame_start, pending;
  logic [3:0] an;
  int errs = 0, checks = 0;
  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .lz_blank(lz_blank), .segs(segs), .dp(dp), .an(an), .frame_start(frame_start),
    .pending(pending)
  );
  always #5 clk = ~clk;
  // Model: a running flag plus a position within the frame, advanced once per cycle.
  logic m_run;
  int m_pos;
  logic [15:0] m_act, m_pval;
  logic [3:0] m_adp, m_pdp, e_an;
  logic m_pend, e_dp, e_fs;
  logic [6:0] e_segs;
  int m_d;
  logic m_lit, m_bnd;
  assign m_d   = m_pos / R;
  assign m_lit = en && m_run && (m_pos % R) >= B && !(lz_blank && m_d > 0 && (m_act >> (4 * m_d)) == 16'h0);
  assign m_bnd = en && (!m_run || m_pos == FR - 1);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_pos <= 0; m_act <= '0; m_adp <= '0; m_pval <= '0; m_pdp <= '0; m_pend <= 1'b0;
      e_an <= 4'hF; e_segs <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
    end else begin
      e_an   <= m_lit ? 4'(~(4'b1 << m_d)) : 4'hF;
      e_segs <= m_lit ? SEG_TBL[4'(m_act >> (4 * m_d))] : 7'h7F;
      e_dp   <= !(m_lit && m_adp[m_d]);
      e_fs   <= m_bnd;
      if (!en || m_bnd) begin
        if (load) begin m_act <= value; m_adp <= dp_in; end
        else if (m_pend) begin m_act <= m_pval; m_adp <= m_pdp; end
        m_pend <= 1'b0;
      end else if (load) m_pend <= 1'b1;
      if (load) begin m_pval <= value; m_pdp <= dp_in; end
      m_run <= en;
      m_pos <= (en && m_run) ? (m_pos + 1) % FR : 0;
    end
  end
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (an !== 4'hF) begin errs++; $display("FAIL reset_an got=%h want=f", an); end
    checks++; if (segs !== 7'h7F) begin errs++; $display("FAIL reset_segs got=%h want=7f", segs); end
    checks++; if (dp !== 1'b1) begin errs++; $display("FAIL reset_dp got=%b want=1", dp); end
    checks++; if (frame_start !== 1'b0) begin errs++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    checks++; if (pending !== 1'b0) begin errs++; $display("FAIL reset_pending got=%b want=0", pending); end
  endtask
  task automatic test_scan();
    int last_fs = -1;
    int lit_cnt [4] = '{0, 0, 0, 0};
    rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h12AF; dp_in = 4'h0;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 3 * FR; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (an !== e_an || segs !== e_segs || dp !== e_dp || frame_start !== e_fs) begin
        errs++; $display("FAIL scan_model c=%0d got an=%b segs=%h dp=%b fs=%b want an=%b segs=%h dp=%b fs=%b",
                         c, an, segs, dp, frame_start, e_an, e_segs, e_dp, e_fs);
      end
      checks++; if ($countones(~an) > 1) begin errs++; $display("FAIL scan_onehot an=%b want at most one low", an); end
      if (frame_start) begin
        if (last_fs >= 0) begin
          checks++; if (c - last_fs != FR) begin errs++; $display("FAIL scan_fs_period got=%0d want=%0d", c - last_fs, FR); end
        end
        last_fs = c;
      end
      if (c >= FR) for (int k = 0; k < 4; k++) if (an == 4'(~(4'b1 << k))) begin
        lit_cnt[k]++;
        checks++; if (segs !== EXP_12AF[k]) begin errs++; $display("FAIL scan_digit%0d segs got=%h want=%h", k, segs, EXP_12AF[k]); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (lit_cnt[k] != 2 * (R - B)) begin errs++; $display("FAIL scan_lit%0d got=%0d want=%0d", k, lit_cnt[k], 2 * (R - B)); end
    end
  endtask
  task automatic test_midframe_load();
    int n = 0;
    do begin @(negedge clk); n++; end while (an !== 4'b1101 && n < 64);
    checks++; if (an !== 4'b1101) begin errs++; $display("FAIL mid_wait an=%b want=1101", an); end
    load = 1'b1; value = 16'h0000;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (!frame_start && n < 40) begin
      checks++; if (pending !== 1'b1) begin errs++; $display("FAIL mid_pending got=%b want=1", pending); end
      for (int k = 0; k < 4; k++) if (an == 4'(~(4'b1 << k))) begin
        checks++; if (segs !== EXP_12AF[k]) begin errs++; $display("FAIL mid_old_digit%0d got=%h want=%h", k, segs, EXP_12AF[k]); end
      end
      @(negedge clk); n++;
    end
    checks++; if (frame_start !== 1'b1) begin errs++; $display("FAIL mid_boundary fs=%b want=1", frame_start); end
    checks++; if (pending !== 1'b0) begin errs++; $display("FAIL mid_pending_clear got=%b want=0", pending); end
    for (int c = 0; c < FR; c++) begin
      @(negedge clk);
      if (an !== 4'hF) begin
        checks++; if (segs !== 7'h40) begin errs++; $display("FAIL mid_new an=%b segs got=%h want=40", an, segs); end
      end
    end
  endtask
  task automatic test_lz();
    logic [15:0] vals [2] = '{16'h0005, 16'h0000};
    logic [6:0] want [2] = '{7'h12, 7'h40};
    lz_blank = 1'b1;
    for (int v = 0; v < 2; v++) begin
      int lit0 = 0, n = 0;
      load = 1'b1; value = vals[v];
      @(negedge clk);
      load = 1'b0;
      while (!frame_start && n < 40) begin @(negedge clk); n++; end
      checks++; if (frame_start !== 1'b1) begin errs++; $display("FAIL lz_wait fs=%b want=1", frame_start); end
      for (int c = 0; c < FR; c++) begin
        @(negedge clk);
        checks++; if (an[3:1] !== 3'b111) begin errs++; $display("FAIL lz_upper val=%h an=%b want an[3:1]=111", vals[v], an); end
        if (!an[0]) begin
          lit0++;
          checks++; if (segs !== want[v]) begin errs++; $display("FAIL lz_digit0 val=%h got=%h want=%h", vals[v], segs, want[v]); end
        end
      end
      checks++; if (lit0 != R - B) begin errs++; $display("FAIL lz_lit0 val=%h got=%0d want=%0d", vals[v], lit0, R - B); end
    end
    lz_blank = 1'b0;
  endtask
  task automatic test_dp();
    int low = 0, n = 0;
    load = 1'b1; value = 16'($urandom); dp_in = 4'b0100;
    @(negedge clk);
    load = 1'b0;
    while (!frame_start && n < 40) begin @(negedge clk); n++; end
    for (int c = 0; c < FR; c++) begin
      @(negedge clk);
      if (!dp) low++;
      checks++; if (dp !== (an != 4'b1011)) begin errs++; $display("FAIL dp_window an=%b dp got=%b want=%b", an, dp, an != 4'b1011); end
    end
    checks++; if (low != R - B) begin errs++; $display("FAIL dp_count got=%0d want=%0d", low, R - B); end
  endtask
  task automatic test_en_drop();
    int n = 0;
    do begin @(negedge clk); n++; end while (an !== 4'b1011 && n < 64);
    checks++; if (an !== 4'b1011) begin errs++; $display("FAIL en_wait an=%b want=1011", an); end
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++; if (an !== 4'hF || segs !== 7'h7F || dp !== 1'b1) begin
        errs++; $display("FAIL en_dark got an=%b segs=%h dp=%b want an=1111 segs=7f dp=1", an, segs, dp);
      end
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin errs++; $display("FAIL en_restart_fs got=%b want=1", frame_start); end
    repeat (B) begin
      @(negedge clk);
      checks++; if (an !== 4'hF) begin errs++; $display("FAIL en_restart_blank an=%b want=1111", an); end
    end
    @(negedge clk);
    checks++; if (an !== 4'b1110) begin errs++; $display("FAIL en_restart_digit0 an=%b want=1110", an); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++; if (an !== e_an || segs !== e_segs || dp !== e_dp || frame_start !== e_fs || pending !== m_pend) begin
        errs++; $display("FAIL rand c=%0d got an=%b segs=%h dp=%b fs=%b pend=%b want an=%b segs=%h dp=%b fs=%b pend=%b",
                         c, an, segs, dp, frame_start, pending, e_an, e_segs, e_dp, e_fs, m_pend);
      end
      load = ($urandom_range(7) == 0);
      value = ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(63) == 0) lz_blank = ~lz_blank;
      if (en && $urandom_range(199) == 0) en = 1'b0;
      else if (!en && $urandom_range(9) == 0) en = 1'b1;
    end
    en = 1'b1; load = 1'b0; lz_blank = 1'b0;
  endtask
  task automatic test_async_reset();
    int n = 0, lit = 0;
    do begin @(negedge clk); n++; end while (an !== 4'b1101 && n < 200);
    checks++; if (an !== 4'b1101) begin errs++; $display("FAIL arst_wait an=%b want=1101", an); end
    load = 1'b1; value = 16'hBEEF; dp_in = 4'hF;
    @(negedge clk);
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errs++; $display("FAIL arst_pending_pre got=%b want=1", pending); end
    #2 rst = 1'b1;
    #1;
    checks++; if (an !== 4'hF || segs !== 7'h7F || dp !== 1'b1 || pending !== 1'b0 || frame_start !== 1'b0) begin
      errs++; $display("FAIL arst_async got an=%b segs=%h dp=%b pend=%b fs=%b want dark, pend=0 fs=0", an, segs, dp, pending, frame_start);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pending !== 1'b0) begin errs++; $display("FAIL arst_pending_post got=%b want=0", pending); end
    for (int c = 0; c < FR; c++) begin
      @(negedge clk);
      if (an !== 4'hF) begin
        lit++;
        checks++; if (segs !== 7'h40 || dp !== 1'b1) begin errs++; $display("FAIL arst_zero an=%b segs=%h dp=%b want segs=40 dp=1", an, segs, dp); end
      end
    end
    checks++; if (lit != N * (R - B)) begin errs++; $display("FAIL arst_lit got=%0d want=%0d", lit, N * (R - B)); end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_lz();
    test_dp();
    test_en_drop();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
